// File: rtl/mips_pkg.sv
// Shared encodings for the multi-cycle MIPS control path: opcodes, datapath
// mux selects, ALU operation codes, FSM states and instruction classes.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FUNC_JR  = 6'b001000;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_FUNC = 3'b010;
  localparam logic [2:0] ALU_SLT  = 3'b011;
  localparam logic [2:0] ALU_AND  = 3'b100;
  localparam logic [2:0] ALU_OR   = 3'b101;

  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;
  localparam logic [1:0] PC_SRC_RS     = 2'b11;

  localparam logic [1:0] SRC_B_REG     = 2'b00;
  localparam logic [1:0] SRC_B_FOUR    = 2'b01;
  localparam logic [1:0] SRC_B_IMM     = 2'b10;
  localparam logic [1:0] SRC_B_IMM_SH2 = 2'b11;

  localparam logic [1:0] DST_RT = 2'b00;
  localparam logic [1:0] DST_RD = 2'b01;
  localparam logic [1:0] DST_RA = 2'b10;

  localparam logic [1:0] WB_ALUOUT = 2'b00;
  localparam logic [1:0] WB_MDR    = 2'b01;
  localparam logic [1:0] WB_PC     = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_EXEC_R, S_WB_R, S_EXEC_I, S_WB_I, S_ADDR,
    S_LOAD, S_STORE, S_LOAD_WB, S_BRANCH, S_JUMP, S_JR, S_JAL
  } state_t;

  typedef enum logic [3:0] {
    CLS_R, CLS_JR, CLS_LW, CLS_SW, CLS_BRANCH, CLS_IMM, CLS_JUMP, CLS_JAL,
    CLS_ILLEGAL
  } instr_class_t;

endpackage

// File: rtl/mc_opcode_decode.sv
// Combinational instruction classifier: opcode/func to instruction class,
// the ALU operation for I-type arithmetic, and an unsupported-opcode flag.
module mc_opcode_decode
  import mips_pkg::*;
(
  input  logic [5:0]   opcode,
  input  logic [5:0]   func,
  output instr_class_t instr_class,
  output logic [2:0]   imm_alu_op,
  output logic         illegal
);

  // Map each supported opcode to its class; anything else is illegal
  always_comb begin
    instr_class = CLS_ILLEGAL;
    imm_alu_op  = ALU_ADD;
    case (opcode)
      OP_RTYPE: instr_class = (func == FUNC_JR) ? CLS_JR : CLS_R;
      OP_LW:    instr_class = CLS_LW;
      OP_SW:    instr_class = CLS_SW;
      OP_BEQ,
      OP_BNE:   instr_class = CLS_BRANCH;
      OP_ADDI:  begin instr_class = CLS_IMM; imm_alu_op = ALU_ADD; end
      OP_SLTI:  begin instr_class = CLS_IMM; imm_alu_op = ALU_SLT; end
      OP_ANDI:  begin instr_class = CLS_IMM; imm_alu_op = ALU_AND; end
      OP_ORI:   begin instr_class = CLS_IMM; imm_alu_op = ALU_OR;  end
      OP_J:     instr_class = CLS_JUMP;
      OP_JAL:   instr_class = CLS_JAL;
      default:  instr_class = CLS_ILLEGAL;
    endcase
  end

  assign illegal = (instr_class == CLS_ILLEGAL);

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM of the multi-cycle MIPS core. One shared memory serves
// instruction and data accesses through a req/ready handshake with timeout.
// Optional feature macro: MC_CTRL_PERF_EN adds cycle_cnt/instr_cnt counters.
module mips_multicycle_ctrl
  import mips_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
)
(
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic [5:0] opcode,
  input  logic [5:0] func,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       iord,
  output logic       ir_write,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       branch_ne,
  output logic [1:0] pc_src,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_op,
  output logic       reg_write,
  output logic [1:0] reg_dst,
  output logic [1:0] mem_to_reg,
  output logic       illegal_op,
  output logic       bus_err,
  output logic       busy
`ifdef MC_CTRL_PERF_EN
  ,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instr_cnt
`endif
);

  localparam int TO_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);

  // Perf counters need at least one bit
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("CNT_W must be at least 1");
  end

  state_t       state, next_state;
  instr_class_t instr_class;
  logic [2:0]   imm_alu_op;
  logic         illegal;
  logic         fetch_active;
  logic [TO_W-1:0] to_cnt;
  logic         req_raw;
  logic         mem_wait;
  logic         timeout;

  mc_opcode_decode u_decode (
    .opcode      (opcode),
    .func        (func),
    .instr_class (instr_class),
    .imm_alu_op  (imm_alu_op),
    .illegal     (illegal)
  );

  // Once a fetch request is raised it must stay up even if run drops,
  // hence fetch_active extends the run qualifier until ready or timeout.
  assign req_raw  = (state == S_FETCH) ? (run || fetch_active)
                                       : ((state == S_LOAD) || (state == S_STORE));
  assign mem_wait = req_raw && !mem_ready;
  assign timeout  = (MEM_TIMEOUT != 0) && mem_wait &&
                    (32'(to_cnt) == 32'(MEM_TIMEOUT - 1));

  // State register plus the handshake bookkeeping
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= S_FETCH;
      fetch_active <= 1'b0;
      to_cnt       <= '0;
    end else begin
      state        <= next_state;
      fetch_active <= (state == S_FETCH) && mem_wait && !timeout;
      to_cnt       <= (mem_wait && !timeout) ? to_cnt + 1'b1 : '0;
    end
  end

  // Next-state selection; memory states hold until ready or timeout
  always_comb begin
    next_state = state;
    case (state)
      S_FETCH:   if (req_raw && mem_ready) next_state = S_DECODE;
      S_DECODE: begin
        case (instr_class)
          CLS_R:      next_state = S_EXEC_R;
          CLS_JR:     next_state = S_JR;
          CLS_LW,
          CLS_SW:     next_state = S_ADDR;
          CLS_BRANCH: next_state = S_BRANCH;
          CLS_IMM:    next_state = S_EXEC_I;
          CLS_JUMP:   next_state = S_JUMP;
          CLS_JAL:    next_state = S_JAL;
          default:    next_state = S_FETCH;
        endcase
      end
      S_EXEC_R:  next_state = S_WB_R;
      S_EXEC_I:  next_state = S_WB_I;
      S_ADDR:    next_state = (instr_class == CLS_SW) ? S_STORE : S_LOAD;
      S_LOAD: begin
        if (mem_ready)    next_state = S_LOAD_WB;
        else if (timeout) next_state = S_FETCH;
      end
      S_STORE:   if (mem_ready || timeout) next_state = S_FETCH;
      default:   next_state = S_FETCH;
    endcase
  end

  // Datapath controls decoded from state; everything forced low in reset
  always_comb begin
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    iord          = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    branch_ne     = 1'b0;
    pc_src        = PC_SRC_ALU;
    alu_src_a     = 1'b0;
    alu_src_b     = SRC_B_REG;
    alu_op        = ALU_ADD;
    reg_write     = 1'b0;
    reg_dst       = DST_RT;
    mem_to_reg    = WB_ALUOUT;
    illegal_op    = 1'b0;
    bus_err       = 1'b0;
    busy          = 1'b0;
    if (rst) begin
      busy    = !((state == S_FETCH) && !req_raw);
      bus_err = timeout;
      case (state)
        S_FETCH: begin
          if (req_raw) begin
            mem_req   = 1'b1;
            alu_src_b = SRC_B_FOUR;
            if (mem_ready) begin
              ir_write = 1'b1;
              pc_write = 1'b1;
            end
          end
        end
        S_DECODE: begin
          alu_src_b  = SRC_B_IMM_SH2;
          illegal_op = illegal;
        end
        S_EXEC_R: begin
          alu_src_a = 1'b1;
          alu_op    = ALU_FUNC;
        end
        S_WB_R: begin
          reg_write = 1'b1;
          reg_dst   = DST_RD;
        end
        S_EXEC_I: begin
          alu_src_a = 1'b1;
          alu_src_b = SRC_B_IMM;
          alu_op    = imm_alu_op;
        end
        S_WB_I:  reg_write = 1'b1;
        S_ADDR: begin
          alu_src_a = 1'b1;
          alu_src_b = SRC_B_IMM;
        end
        S_LOAD: begin
          mem_req = 1'b1;
          iord    = 1'b1;
        end
        S_STORE: begin
          mem_req = 1'b1;
          iord    = 1'b1;
          mem_we  = 1'b1;
        end
        S_LOAD_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = WB_MDR;
        end
        S_BRANCH: begin
          alu_src_a     = 1'b1;
          alu_op        = ALU_SUB;
          pc_write_cond = 1'b1;
          pc_src        = PC_SRC_ALUOUT;
          branch_ne     = opcode[0];
        end
        S_JUMP: begin
          pc_write = 1'b1;
          pc_src   = PC_SRC_JUMP;
        end
        S_JR: begin
          pc_write = 1'b1;
          pc_src   = PC_SRC_RS;
        end
        S_JAL: begin
          pc_write   = 1'b1;
          pc_src     = PC_SRC_JUMP;
          reg_write  = 1'b1;
          reg_dst    = DST_RA;
          mem_to_reg = WB_PC;
        end
        default: ;
      endcase
    end
  end

`ifdef MC_CTRL_PERF_EN
  // Busy cycles and retired instructions (every return to FETCH)
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycle_cnt <= '0;
      instr_cnt <= '0;
    end else begin
      if (busy) cycle_cnt <= cycle_cnt + 1'b1;
      if ((state != S_FETCH) && (next_state == S_FETCH)) instr_cnt <= instr_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Self-checking bench for mips_multicycle_ctrl: directed scenarios plus a
// randomized instruction stream compared cycle by cycle with a per-instruction
// reference model. Perf counter checks run when MC_CTRL_PERF_EN is defined.
module tb_mips_multicycle_ctrl;

  localparam int TO = 4;

  localparam int C_R = 0, C_JR = 1, C_LW = 2, C_SW = 3, C_BR = 4, C_IMM = 5,
                 C_J = 6, C_JAL = 7, C_ILL = 8;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic       ir_write;
    logic       pc_write;
    logic       pc_write_cond;
    logic       branch_ne;
    logic [1:0] pc_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       illegal_op;
    logic       bus_err;
    logic       busy;
  } ctl_t;

  logic       clk = 1'b0;
  logic       rst, run, mem_ready;
  logic [5:0] opcode, func;
  logic       mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond, branch_ne;
  logic [1:0] pc_src, alu_src_b, reg_dst, mem_to_reg;
  logic       alu_src_a, reg_write, illegal_op, bus_err, busy;
  logic [2:0] alu_op;
`ifdef MC_CTRL_PERF_EN
  logic [3:0] cycle_cnt, instr_cnt;
`endif

  ctl_t got;
  int   testsRun = 0;
  int   testsFailed = 0;
  int   cyc = 0;
  bit   stampEn = 1'b0;
  bit   tieReady = 1'b0;
  int   stamps[$];

  mips_multicycle_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .run(run), .opcode(opcode), .func(func),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .iord(iord),
    .ir_write(ir_write), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
    .branch_ne(branch_ne), .pc_src(pc_src), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .reg_write(reg_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .illegal_op(illegal_op),
    .bus_err(bus_err), .busy(busy)
`ifdef MC_CTRL_PERF_EN
    , .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
`endif
  );

  assign got = {mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond, branch_ne,
                pc_src, alu_src_a, alu_src_b, alu_op, reg_write, reg_dst, mem_to_reg,
                illegal_op, bus_err, busy};

  // Free-running core clock
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h expected %h (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  function automatic int classify(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      6'b000000: return (fn == 6'b001000) ? C_JR : C_R;
      6'b100011: return C_LW;
      6'b101011: return C_SW;
      6'b000100, 6'b000101: return C_BR;
      6'b001000, 6'b001010, 6'b001100, 6'b001101: return C_IMM;
      6'b000010: return C_J;
      6'b000011: return C_JAL;
      default:   return C_ILL;
    endcase
  endfunction

  function automatic logic [2:0] immAluOp(input logic [5:0] op);
    case (op)
      6'b001010: return 3'b011;
      6'b001100: return 3'b100;
      6'b001101: return 3'b101;
      default:   return 3'b000;
    endcase
  endfunction

  function automatic ctl_t busyOnly();
    ctl_t e = '0;
    e.busy = 1'b1;
    return e;
  endfunction

  function automatic ctl_t fetchBase();
    ctl_t e = busyOnly();
    e.mem_req   = 1'b1;
    e.alu_src_b = 2'b01;
    return e;
  endfunction

  // One clock: inputs already driven, compare, then step to posedge+1
  task automatic runCycle(input ctl_t e, input string tag);
    #1;
    checkOutput(tag, {9'b0, got}, {9'b0, e});
    if (stampEn && got.ir_write) stamps.push_back(cyc);
    cyc++;
    @(posedge clk);
    #1;
  endtask

  // Non-memory cycle: mem_ready and run are don't-cares for the DUT
  task automatic plainCycle(input ctl_t e, input string tag);
    mem_ready = tieReady ? 1'b1 : 1'($urandom_range(0, 1));
    run       = tieReady ? 1'b1 : 1'($urandom_range(0, 1));
    runCycle(e, tag);
  endtask

  task automatic memPhase(input ctl_t base, input int waits, input bit isFetch,
                          input string tag, output bit ok);
    ctl_t e;
    ok = 1'b0;
    for (int i = 0; i < TO; i++) begin
      mem_ready = tieReady || (i == waits);
      if (isFetch && i > 0 && !tieReady) run = 1'($urandom_range(0, 1));
      e = base;
      if (mem_ready) begin
        if (isFetch) begin
          e.ir_write = 1'b1;
          e.pc_write = 1'b1;
        end
        ok = 1'b1;
      end else if (i == TO - 1) begin
        e.bus_err = 1'b1;
      end
      runCycle(e, tag);
      if (mem_ready || e.bus_err) break;
    end
  endtask

  task automatic runInstr(input logic [5:0] op, input logic [5:0] fn,
                          input int fWait, input int dWait, input string tag);
    ctl_t e;
    bit   ok;
    int   cls;
    opcode = op;
    func   = fn;
    cls    = classify(op, fn);
    run    = 1'b1;
    memPhase(fetchBase(), fWait, 1'b1, {tag, "/fetch"}, ok);
    if (!ok) begin
      run = 1'b1;
      memPhase(fetchBase(), 0, 1'b1, {tag, "/refetch"}, ok);
    end
    e = busyOnly();
    e.alu_src_b  = 2'b11;
    e.illegal_op = (cls == C_ILL);
    plainCycle(e, {tag, "/decode"});
    e = busyOnly();
    case (cls)
      C_R: begin
        e.alu_src_a = 1'b1; e.alu_op = 3'b010;
        plainCycle(e, {tag, "/exec_r"});
        e = busyOnly(); e.reg_write = 1'b1; e.reg_dst = 2'b01;
        plainCycle(e, {tag, "/wb_r"});
      end
      C_IMM: begin
        e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; e.alu_op = immAluOp(op);
        plainCycle(e, {tag, "/exec_i"});
        e = busyOnly(); e.reg_write = 1'b1;
        plainCycle(e, {tag, "/wb_i"});
      end
      C_LW, C_SW: begin
        e.alu_src_a = 1'b1; e.alu_src_b = 2'b10;
        plainCycle(e, {tag, "/addr"});
        e = busyOnly(); e.mem_req = 1'b1; e.iord = 1'b1; e.mem_we = (cls == C_SW);
        memPhase(e, dWait, 1'b0, {tag, "/data"}, ok);
        if (ok && cls == C_LW) begin
          e = busyOnly(); e.reg_write = 1'b1; e.mem_to_reg = 2'b01;
          plainCycle(e, {tag, "/load_wb"});
        end
      end
      C_BR: begin
        e.alu_src_a = 1'b1; e.alu_op = 3'b001; e.pc_write_cond = 1'b1;
        e.pc_src = 2'b01; e.branch_ne = op[0];
        plainCycle(e, {tag, "/branch"});
      end
      C_J: begin
        e.pc_write = 1'b1; e.pc_src = 2'b10;
        plainCycle(e, {tag, "/jump"});
      end
      C_JR: begin
        e.pc_write = 1'b1; e.pc_src = 2'b11;
        plainCycle(e, {tag, "/jr"});
      end
      C_JAL: begin
        e.pc_write = 1'b1; e.pc_src = 2'b10; e.reg_write = 1'b1;
        e.reg_dst = 2'b10; e.mem_to_reg = 2'b10;
        plainCycle(e, {tag, "/jal"});
      end
      default: ;
    endcase
  endtask

  task automatic applyReset();
    rst = 1'b0; run = 1'b1; mem_ready = 1'b0;
    #1;
    checkOutput("reset_outputs", {9'b0, got}, 32'h0);
`ifdef MC_CTRL_PERF_EN
    checkOutput("reset_cycle_cnt", {28'b0, cycle_cnt}, 32'h0);
    checkOutput("reset_instr_cnt", {28'b0, instr_cnt}, 32'h0);
`endif
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  // Random instruction stream with random memory latency and idle gaps
  task automatic applyStimulus(input int count);
    logic [5:0] opTab [11] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000101,
                               6'b001000, 6'b001010, 6'b001100, 6'b001101, 6'b000010,
                               6'b000011};
    logic [5:0] op, fn;
    int pick, fWait, dWait;
    for (int n = 0; n < count; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        repeat ($urandom_range(1, 2)) begin
          run = 1'b0;
          mem_ready = 1'($urandom_range(0, 1));
          runCycle('0, "rand/idle");
        end
      end
      pick = $urandom_range(0, 12);
      fn   = 6'($urandom);
      if (pick < 11) op = opTab[pick];
      else if (pick == 11) op = 6'($urandom);
      else begin op = 6'b000000; fn = 6'b001000; end
      fWait = ($urandom_range(0, 9) == 0) ? TO : $urandom_range(0, 2);
      dWait = ($urandom_range(0, 6) == 0) ? TO : $urandom_range(0, 3);
      runInstr(op, fn, fWait, dWait, $sformatf("rand%0d_op%b", n, op));
    end
  endtask

  initial begin
    int expDiff [6] = '{4, 4, 5, 4, 3, 3};
    ctl_t e;
    opcode = 6'b0; func = 6'b0;
    applyReset();

    // Zero-wait program: add, addi, lw, sw, beq, j, then add to close the window
    tieReady = 1'b1;
    stampEn  = 1'b1;
    runInstr(6'b000000, 6'b100000, 0, 0, "prog_add");
    runInstr(6'b001000, 6'b000000, 0, 0, "prog_addi");
    runInstr(6'b100011, 6'b000000, 0, 0, "prog_lw");
    runInstr(6'b101011, 6'b000000, 0, 0, "prog_sw");
    runInstr(6'b000100, 6'b000000, 0, 0, "prog_beq");
    runInstr(6'b000010, 6'b000000, 0, 0, "prog_j");
    runInstr(6'b000000, 6'b100000, 0, 0, "prog_add2");
    stampEn  = 1'b0;
    tieReady = 1'b0;
    checkOutput("prog_fetch_count", 32'(stamps.size()), 32'd7);
    if (stamps.size() == 7)
      for (int k = 0; k < 6; k++)
        checkOutput($sformatf("prog_latency%0d", k), 32'(stamps[k+1] - stamps[k]), 32'(expDiff[k]));

    runInstr(6'b100011, 6'b0, 0, 3, "lw_slow");
    runInstr(6'b000000, 6'b100000, TO, 0, "fetch_timeout");
    runInstr(6'b101011, 6'b0, 1, TO, "sw_timeout");
    runInstr(6'b111111, 6'b0, 0, 0, "illegal");
    runInstr(6'b000011, 6'b0, 0, 0, "jal");
    runInstr(6'b000101, 6'b0, 2, 0, "bne");
    runInstr(6'b000000, 6'b001000, 0, 0, "jr");

    // Reset asserted while a load waits on memory
    opcode = 6'b100011; func = 6'b0;
    run = 1'b1; mem_ready = 1'b1;
    runCycle(fetchBase() | ctl_t'({3'b0, 2'b11, 18'b0}), "rstlw/fetch");
    e = busyOnly(); e.alu_src_b = 2'b11;
    plainCycle(e, "rstlw/decode");
    e = busyOnly(); e.alu_src_a = 1'b1; e.alu_src_b = 2'b10;
    plainCycle(e, "rstlw/addr");
    mem_ready = 1'b0;
    e = busyOnly(); e.mem_req = 1'b1; e.iord = 1'b1;
    runCycle(e, "rstlw/load");
    rst = 1'b0;
    #1;
    checkOutput("rst_mid_load", {9'b0, got}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    runInstr(6'b000000, 6'b100000, 1, 0, "after_rst");

    applyStimulus(200);

`ifdef MC_CTRL_PERF_EN
    applyReset();
    tieReady = 1'b1;
    for (int n = 0; n < 20; n++) runInstr(6'b000000, 6'b100000, 0, 0, "perf_add");
    tieReady = 1'b0;
    checkOutput("perf_instr_cnt", {28'b0, instr_cnt}, 32'(20 % 16));
    checkOutput("perf_cycle_cnt", {28'b0, cycle_cnt}, 32'((20 * 4) % 16));
`endif

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
